// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with redirect, stall, halt and alignment check
module pc_unit #(
    parameter int             N            = 64,
    parameter logic [N-1:0]   RESET_VECTOR = '0,
    parameter logic [N-1:0]   TRAP_VECTOR  = N'('h100),
    parameter logic [N-1:0]   INC          = N'(4),
    parameter int             ALIGN_BITS   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                halt,
    input  logic                resume,
    input  logic                branch_taken,
    input  logic [N-1:0]        branch_target,
    input  logic                jump,
    input  logic [N-1:0]        jump_target,
    input  logic                trap,
    input  logic                fetch_ready,
    output logic                fetch_valid,
    output logic signed [N-1:0] pc,
    output logic [N-1:0]        pc_prev,
    output logic                misaligned,
    output logic [N-1:0]        bad_target,
    output logic                halted
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Low bits of a target that must be clear; a zero-width check yields an empty mask.
    localparam logic [N-1:0] ALIGN_MASK = (N'(1) << ALIGN_BITS) - N'(1);

    state_t       state;
    logic [N-1:0] pc_q;
    logic         handshake;
    logic         redirect;
    logic [N-1:0] target;
    logic         target_bad;

    // Fetch may only see the PC while running and not stalled.
    assign fetch_valid = (state == RUN) && !stall;
    assign handshake   = fetch_valid && fetch_ready;
    assign pc          = pc_q;
    assign halted      = (state == HALTED);

    // Jump outranks branch; the chosen target is checked for alignment before use.
    always_comb begin
        redirect   = jump || branch_taken;
        target     = jump ? jump_target : branch_target;
        target_bad = (target & ALIGN_MASK) != '0;
    end

    // PC, history and fault capture; every update lands on the edge after the request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc_q       <= RESET_VECTOR;
            pc_prev    <= '0;
            bad_target <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (trap || redirect) begin
                        // The instruction handed over this cycle was still accepted.
                        if (handshake) pc_prev <= pc_q;
                        if (trap) begin
                            pc_q <= TRAP_VECTOR;
                        end else if (target_bad) begin
                            pc_q       <= TRAP_VECTOR;
                            bad_target <= target;
                            misaligned <= 1'b1;
                        end else begin
                            pc_q <= target;
                        end
                        if (halt) state <= HALTED;
                    end else if (halt) begin
                        state <= HALTED;
                    end else if (handshake) begin
                        pc_q    <= pc_q + INC;
                        pc_prev <= pc_q;
                    end
                end
                HALTED: begin
                    if (trap) begin
                        pc_q  <= TRAP_VECTOR;
                        state <= RUN;
                    end else begin
                        if (redirect) begin
                            if (target_bad) begin
                                pc_q       <= TRAP_VECTOR;
                                bad_target <= target;
                                misaligned <= 1'b1;
                            end else begin
                                pc_q <= target;
                            end
                        end
                        // resume takes precedence over a simultaneous halt.
                        if (resume) state <= RUN;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        halt;
    logic        resume;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        jump;
    logic [63:0] jump_target;
    logic        trap;
    logic        fetch_ready;
    logic        fetch_valid;
    logic signed [63:0] pc;
    logic [63:0] pc_prev;
    logic        misaligned;
    logic [63:0] bad_target;
    logic        halted;

    int total = 0;
    int bad   = 0;

    pc_unit #(
        .N           (64),
        .RESET_VECTOR(64'h0),
        .TRAP_VECTOR (64'h100),
        .INC         (64'd4),
        .ALIGN_BITS  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .halt         (halt),
        .resume       (resume),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .trap         (trap),
        .fetch_ready  (fetch_ready),
        .fetch_valid  (fetch_valid),
        .pc           (pc),
        .pc_prev      (pc_prev),
        .misaligned   (misaligned),
        .bad_target   (bad_target),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        jump = 1'b0; branch_taken = 1'b0; trap = 1'b0;
        halt = 1'b0; resume = 1'b0; stall = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_ready = 1'b1;
        jump_target = '0; branch_target = '0;
        clear_redirects();

        // reset and boot
        step(); step();
        check("rst_pc", pc, 64'h0);
        check("rst_prev", pc_prev, 64'h0);
        check("rst_bad", bad_target, 64'h0);
        check("rst_mis", {63'd0, misaligned}, 64'd0);
        check("rst_fv", {63'd0, fetch_valid}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("boot_fv", {63'd0, fetch_valid}, 64'd0);
        step();
        check("run_fv", {63'd0, fetch_valid}, 64'd1);
        check("run_pc0", pc, 64'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", pc, 64'(4 * i));
            check("seq_prev", pc_prev, 64'(4 * (i - 1)));
        end

        // backpressure then stall at 0x10
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_pc", pc, 64'h10);
        end
        fetch_ready = 1'b1; stall = 1'b1;
        #1;
        check("stall_fv", {63'd0, fetch_valid}, 64'd0);
        step(); step();
        check("stall_pc", pc, 64'h10);
        stall = 1'b0;
        step();
        check("post_stall_pc", pc, 64'h14);
        check("post_stall_prev", pc_prev, 64'h10);
        step(); step(); step();
        check("at_20", pc, 64'h20);

        // jump beats branch; handshake in same cycle updates pc_prev
        jump = 1'b1; jump_target = 64'h80;
        branch_taken = 1'b1; branch_target = 64'h40;
        step();
        check("jmp_win_pc", pc, 64'h80);
        check("jmp_win_prev", pc_prev, 64'h20);
        trap = 1'b1;
        step();
        check("trap_pc", pc, 64'h100);
        clear_redirects();

        // misaligned branch target
        branch_taken = 1'b1; branch_target = 64'h42;
        step();
        branch_taken = 1'b0;
        check("mis_pc", pc, 64'h100);
        check("mis_bad", bad_target, 64'h42);
        check("mis_pulse", {63'd0, misaligned}, 64'd1);
        step();
        check("mis_clear", {63'd0, misaligned}, 64'd0);
        check("mis_next_pc", pc, 64'h104);

        // halt / resume
        jump = 1'b1; jump_target = 64'h30;
        step();
        jump = 1'b0;
        check("to_30", pc, 64'h30);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halted", {63'd0, halted}, 64'd1);
        check("halt_pc", pc, 64'h30);
        check("halt_fv", {63'd0, fetch_valid}, 64'd0);
        for (int i = 0; i < 10; i++) step();
        check("halt_hold", pc, 64'h30);
        jump = 1'b1; jump_target = 64'h200;
        step();
        jump = 1'b0;
        check("halt_jmp_pc", pc, 64'h200);
        check("halt_jmp_st", {63'd0, halted}, 64'd1);
        halt = 1'b1; resume = 1'b1;
        step();
        halt = 1'b0; resume = 1'b0;
        check("resume_st", {63'd0, halted}, 64'd0);
        check("resume_fv", {63'd0, fetch_valid}, 64'd1);
        step();
        check("resume_pc1", pc, 64'h204);
        check("resume_prev1", pc_prev, 64'h200);
        step();
        check("resume_pc2", pc, 64'h208);

        // wrap at 2^64
        jump = 1'b1; jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        jump = 1'b0;
        check("pre_wrap", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("wrap_pc", pc, 64'h0);
        check("wrap_prev", pc_prev, 64'hFFFF_FFFF_FFFF_FFFC);

        // reset while halted with a misaligned jump pending
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt2", {63'd0, halted}, 64'd1);
        rst_n = 1'b0; jump = 1'b1; jump_target = 64'h43;
        step();
        check("mid_rst_pc", pc, 64'h0);
        check("mid_rst_halted", {63'd0, halted}, 64'd0);
        check("mid_rst_mis", {63'd0, misaligned}, 64'd0);
        check("mid_rst_bad", bad_target, 64'h0);
        check("mid_rst_fv", {63'd0, fetch_valid}, 64'd0);

        // redirect during boot is ignored
        rst_n = 1'b1; jump_target = 64'h80;
        step();
        jump = 1'b0;
        check("boot_ignore_pc", pc, 64'h0);
        check("boot_to_run", {63'd0, fetch_valid}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
